led_seq_checker: RTL and testbench

- Receiving end of the sequencer-to-LED path. Observes the 8-bit one-hot LED bus and the per-step tick strobe, then encodes each LED pattern back to a 3-bit step index.
- Locks onto the running sequence, flags out-of-order or malformed patterns, and counts errors. Detects a stalled sequence when ticks stop arriving.
- Sits beside the decoder, passive on the LED bus. Its outputs feed debug LEDs or a testbench monitor.

---
 rtl/led_seq_pkg.sv | 32 +++
 rtl/led_seq_checker_if.sv | 39 +++
 rtl/onehot_enc8.sv | 30 +++
 rtl/led_seq_checker.sv | 191 +++++++++++++++++++
 tb/tb_led_seq_checker.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequence checker and any other
// consumer of the sequencer's one-hot LED bus.
`timescale 1ns/1ps
package led_seq_pkg;

    // Checker FSM: hunting for a run of correct steps, or tracking a locked run.
    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int IDX_W = 3;
    localparam int LED_W = 8;

    localparam logic [7:0] ERR_MAX = 8'hFF;

    // Index the sequencer should show after idx; the 3-bit wrap is intentional.
    function automatic logic [IDX_W-1:0] step_idx(input logic [IDX_W-1:0] idx,
                                                   input logic            dir);
        logic [IDX_W-1:0] nxt;
        nxt = dir ? (idx - 3'd1) : (idx + 3'd1);
        return nxt;
    endfunction

    // Increment that sticks at ERR_MAX instead of wrapping back to zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        logic [7:0] res;
        res = (val == ERR_MAX) ? val : (val + 8'd1);
        return res;
    endfunction

endpackage

// File: rtl/led_seq_checker_if.sv
// Bundle of the LED-bus observation signals and the checker's status outputs.
// master = stimulus/monitor side, slave = the checker itself.
`timescale 1ns/1ps
interface led_seq_checker_if;
    import led_seq_pkg::*;

    logic             tick;
    logic [LED_W-1:0] led;
    logic             clr_err;

    logic             locked;
    logic             err_pulse;
    logic [7:0]       err_count;
    logic [IDX_W-1:0] cur_idx;
    logic             stall;

    modport master (
        output tick,
        output led,
        output clr_err,
        input  locked,
        input  err_pulse,
        input  err_count,
        input  cur_idx,
        input  stall
    );

    modport slave (
        input  tick,
        input  led,
        input  clr_err,
        output locked,
        output err_pulse,
        output err_count,
        output cur_idx,
        output stall
    );

endinterface

// File: rtl/onehot_enc8.sv
// Combinational one-hot encoder for the 8-bit LED bus. o_valid is high only
// when exactly one bit is set; o_idx is that bit's position (don't-care when
// o_valid is low).
`timescale 1ns/1ps
module onehot_enc8
    import led_seq_pkg::*;
(
    input  logic [LED_W-1:0] i_led,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_cnt;

    // OR together the positions of set bits and count them; for a one-hot
    // input the OR is exactly the position of the single set bit.
    always_comb begin
        w_idx = 3'd0;
        w_cnt = 4'd0;
        for (int i = 0; i < LED_W; i++) begin
            w_idx = w_idx | (i_led[i] ? 3'(i) : 3'd0);
            w_cnt = w_cnt + {3'd0, i_led[i]};
        end
    end

    assign o_idx   = w_idx;
    assign o_valid = (w_cnt == 4'd1);

endmodule

// File: rtl/led_seq_checker.sv
// Passive checker on the sequencer-to-LED path. Samples the LED bus one cycle
// after each tick, locks onto a run of correctly ordered steps, then flags
// out-of-order or malformed patterns and tick stalls while locked.
`timescale 1ns/1ps
module led_seq_checker
    import led_seq_pkg::*;
#(
    parameter int LOCK_COUNT = 3,
    parameter bit DIR        = 1'b0,
    parameter int TIMEOUT    = 100_000_000
) (
    input logic              clk,
    input logic              rst,
    led_seq_checker_if.slave bus
);

    localparam int               TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_ZERO  = {TO_W{1'b0}};
    localparam logic [TO_W-1:0]  TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       LC       = 4'(LOCK_COUNT);

    // Registered state.
    state_e           r_state;
    logic             r_samp;
    logic [3:0]       r_match;
    logic [IDX_W-1:0] r_exp;
    logic             r_prev_valid;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_err_pulse;
    logic [7:0]       r_err_count;
    logic [IDX_W-1:0] r_cur_idx;
    logic             r_stall;

    // Next-state / event wires.
    state_e           w_state_nxt;
    logic [3:0]       w_match_nxt;
    logic [3:0]       w_match_inc;
    logic [IDX_W-1:0] w_exp_nxt;
    logic             w_prev_valid_nxt;
    logic [TO_W-1:0]  w_to_nxt;
    logic [TO_W-1:0]  w_to_inc;
    logic [IDX_W-1:0] w_cur_idx_nxt;
    logic             w_err_ev;
    logic             w_stall_set;

    // Encoded view of the LED bus.
    logic [IDX_W-1:0] w_idx;
    logic             w_valid;

    onehot_enc8 u_enc (
        .i_led   (bus.led),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    // A sample continues the run only if the previous sample was valid and
    // this one is the index it predicted; otherwise a new run starts at 1.
    assign w_match_inc = (r_prev_valid && (w_idx == r_exp)) ? (r_match + 4'd1) : 4'd1;
    assign w_to_inc    = r_to_cnt + TO_ONE;

    // Next-state logic: sequence tracking on sample cycles, tick timeout
    // between samples while locked.
    always_comb begin
        w_state_nxt      = r_state;
        w_match_nxt      = r_match;
        w_exp_nxt        = r_exp;
        w_prev_valid_nxt = r_prev_valid;
        w_to_nxt         = TO_ZERO;
        w_cur_idx_nxt    = r_cur_idx;
        w_err_ev         = 1'b0;
        w_stall_set      = 1'b0;

        case (r_state)
            SEARCH: begin
                // No errors are counted while hunting; bad samples only
                // restart the run.
                if (r_samp) begin
                    if (w_valid) begin
                        w_cur_idx_nxt    = w_idx;
                        w_exp_nxt        = step_idx(w_idx, DIR);
                        w_prev_valid_nxt = 1'b1;
                        w_match_nxt      = w_match_inc;
                        if (w_match_inc >= LC) begin
                            w_state_nxt = LOCKED;
                        end else begin
                            w_state_nxt = SEARCH;
                        end
                    end else begin
                        w_match_nxt      = 4'd0;
                        w_prev_valid_nxt = 1'b0;
                    end
                end else begin
                    w_match_nxt = r_match;
                end
            end

            LOCKED: begin
                if (r_samp) begin
                    if (w_valid && (w_idx == r_exp)) begin
                        w_cur_idx_nxt = w_idx;
                        w_exp_nxt     = step_idx(w_idx, DIR);
                    end else begin
                        w_err_ev         = 1'b1;
                        w_state_nxt      = SEARCH;
                        w_match_nxt      = 4'd0;
                        w_prev_valid_nxt = 1'b0;
                    end
                end else if (w_to_inc == TO_LIMIT) begin
                    // Ticks have stopped for too long.
                    w_err_ev         = 1'b1;
                    w_stall_set      = 1'b1;
                    w_state_nxt      = SEARCH;
                    w_match_nxt      = 4'd0;
                    w_prev_valid_nxt = 1'b0;
                end else begin
                    w_to_nxt = w_to_inc;
                end
            end

            default: begin
                w_state_nxt      = SEARCH;
                w_match_nxt      = 4'd0;
                w_prev_valid_nxt = 1'b0;
            end
        endcase
    end

    // Sample strobe, FSM state and sequence-tracking registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= SEARCH;
            r_samp       <= 1'b0;
            r_match      <= 4'd0;
            r_exp        <= 3'd0;
            r_prev_valid <= 1'b0;
            r_to_cnt     <= TO_ZERO;
            r_cur_idx    <= 3'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_samp       <= bus.tick;
            r_match      <= w_match_nxt;
            r_exp        <= w_exp_nxt;
            r_prev_valid <= w_prev_valid_nxt;
            r_to_cnt     <= w_to_nxt;
            r_cur_idx    <= w_cur_idx_nxt;
        end
    end

    // One-cycle error pulse; fires even when clr_err hides the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_err_ev;
        end
    end

    // Saturating error counter; a clear in the same cycle as an error wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_count <= 8'd0;
        end else if (bus.clr_err) begin
            r_err_count <= 8'd0;
        end else if (w_err_ev) begin
            r_err_count <= sat_inc8(r_err_count);
        end else begin
            r_err_count <= r_err_count;
        end
    end

    // Sticky stall flag, cleared only by clr_err or reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall <= 1'b0;
        end else if (bus.clr_err) begin
            r_stall <= 1'b0;
        end else if (w_stall_set) begin
            r_stall <= 1'b1;
        end else begin
            r_stall <= r_stall;
        end
    end

    assign bus.locked    = (r_state == LOCKED);
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_count = r_err_count;
    assign bus.cur_idx   = r_cur_idx;
    assign bus.stall     = r_stall;

endmodule

// File: tb/tb_led_seq_checker.sv
// Bench for led_seq_checker: two instances (up and down direction) checked
// every cycle against a behavioural model, plus hand-computed expectations.
`timescale 1ns/1ps
module tb_led_seq_checker;

    localparam int TMO = 20;
    localparam int LCN = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    led_seq_checker_if ifa ();
    led_seq_checker_if ifb ();

    led_seq_checker #(.LOCK_COUNT(LCN), .DIR(1'b0), .TIMEOUT(TMO)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    led_seq_checker #(.LOCK_COUNT(LCN), .DIR(1'b1), .TIMEOUT(TMO)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    // ---------------- behavioural model (index 0 = dut_a, 1 = dut_b) -------
    int m_locked[2], m_match[2], m_exp[2], m_prev[2], m_samp[2];
    int m_to[2], m_cnt[2], m_stall[2], m_cur[2], m_pulse[2];

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            m_locked[k] = 0; m_match[k] = 0; m_exp[k] = 0; m_prev[k] = 0;
            m_samp[k] = 0; m_to[k] = 0; m_cnt[k] = 0; m_stall[k] = 0;
            m_cur[k] = 0; m_pulse[k] = 0;
        end
    endtask

    function automatic int nxt_idx(input int idx, input int dir);
        return (dir != 0) ? ((idx + 7) % 8) : ((idx + 1) % 8);
    endfunction

    task automatic mstep(input int k, input logic tk, input logic [7:0] ld,
                         input logic clr, input int dir);
        bit ok;
        bit ev;
        int idx;
        int was_samp;
        ok       = ($countones(ld) == 1);
        idx      = ok ? $clog2(ld) : 0;
        ev       = 1'b0;
        was_samp = m_samp[k];
        m_samp[k]  = tk ? 1 : 0;
        m_pulse[k] = 0;
        if (was_samp != 0) begin
            if (m_locked[k] == 0) begin
                if (ok) begin
                    m_match[k] = (m_prev[k] != 0 && idx == m_exp[k]) ? m_match[k] + 1 : 1;
                    m_cur[k]   = idx;
                    m_exp[k]   = nxt_idx(idx, dir);
                    m_prev[k]  = 1;
                    if (m_match[k] >= LCN) m_locked[k] = 1;
                end else begin
                    m_match[k] = 0;
                    m_prev[k]  = 0;
                end
            end else if (ok && idx == m_exp[k]) begin
                m_cur[k] = idx;
                m_exp[k] = nxt_idx(idx, dir);
                m_to[k]  = 0;
            end else begin
                ev = 1'b1;
            end
        end else if (m_locked[k] != 0) begin
            if (m_to[k] + 1 == TMO) begin
                ev = 1'b1;
                m_stall[k] = 1;
            end else begin
                m_to[k] = m_to[k] + 1;
            end
        end
        if (ev) begin
            m_locked[k] = 0; m_match[k] = 0; m_prev[k] = 0; m_to[k] = 0;
            m_pulse[k]  = 1;
            if (m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
        end
        if (clr) begin
            m_cnt[k]   = 0;
            m_stall[k] = 0;
        end
    endtask

    // Advance the model on every clock edge; reset follows rst asynchronously.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mreset();
        end else begin
            mstep(0, ifa.tick, ifa.led, ifa.clr_err, 0);
            mstep(1, ifb.tick, ifb.led, ifb.clr_err, 1);
        end
    end

    // ---------------- checking --------------------------------------------
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic lit(input string nm, input int dut_v, input int mdl_v, input int exp);
        chk({nm, "_dut"}, dut_v, exp);
        chk({nm, "_mdl"}, mdl_v, exp);
    endtask

    // Compare every DUT output to the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_locked",    int'(ifa.locked),    m_locked[0]);
            chk("a_err_pulse", int'(ifa.err_pulse), m_pulse[0]);
            chk("a_err_count", int'(ifa.err_count), m_cnt[0]);
            chk("a_cur_idx",   int'(ifa.cur_idx),   m_cur[0]);
            chk("a_stall",     int'(ifa.stall),     m_stall[0]);
            chk("b_locked",    int'(ifb.locked),    m_locked[1]);
            chk("b_err_pulse", int'(ifb.err_pulse), m_pulse[1]);
            chk("b_err_count", int'(ifb.err_count), m_cnt[1]);
            chk("b_cur_idx",   int'(ifb.cur_idx),   m_cur[1]);
            chk("b_stall",     int'(ifb.stall),     m_stall[1]);
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic step_a(input logic [7:0] v, input int gap);
        ifa.tick = 1'b1;
        ifa.led  = v;
        cyc(1);
        ifa.tick = 1'b0;
        cyc(gap - 1);
    endtask

    task automatic step_b(input logic [7:0] v, input int gap);
        ifb.tick = 1'b1;
        ifb.led  = v;
        cyc(1);
        ifb.tick = 1'b0;
        cyc(gap - 1);
    endtask

    // ---------------- directed sequence -----------------------------------
    initial begin
        ifa.tick = 1'b0; ifa.led = 8'h00; ifa.clr_err = 1'b0;
        ifb.tick = 1'b0; ifb.led = 8'h00; ifb.clr_err = 1'b0;
        rst = 1'b0;
        cyc(3);
        lit("rst_locked", int'(ifa.locked),    m_locked[0], 0);
        lit("rst_errcnt", int'(ifa.err_count), m_cnt[0],    0);
        lit("rst_cur",    int'(ifa.cur_idx),   m_cur[0],    0);
        lit("rst_stall",  int'(ifa.stall),     m_stall[0],  0);
        lit("rst_pulse",  int'(ifa.err_pulse), m_pulse[0],  0);
        chk_en = 1'b1;
        rst = 1'b1;
        cyc(2);

        // Up sequence: lock appears one cycle after the third matching sample.
        step_a(8'h01, 10);
        step_a(8'h02, 10);
        ifa.tick = 1'b1; ifa.led = 8'h04;
        cyc(1);
        ifa.tick = 1'b0;
        lit("lock_samp_cycle", int'(ifa.locked), m_locked[0], 0);
        cyc(1);
        lit("lock_next_cycle", int'(ifa.locked), m_locked[0], 1);
        cyc(8);
        step_a(8'h08, 10);
        step_a(8'h10, 10);
        lit("up_cur4",   int'(ifa.cur_idx),   m_cur[0], 4);
        lit("up_errcnt", int'(ifa.err_count), m_cnt[0], 0);

        // Wrap 7 -> 0 while locked.
        step_a(8'h20, 10);
        step_a(8'h40, 10);
        step_a(8'h80, 10);
        step_a(8'h01, 10);
        lit("wrap_locked", int'(ifa.locked),    m_locked[0], 1);
        lit("wrap_errcnt", int'(ifa.err_count), m_cnt[0],    0);
        lit("wrap_cur0",   int'(ifa.cur_idx),   m_cur[0],    0);

        // At idx 2, show 0x10 instead of 0x08.
        step_a(8'h02, 10);
        step_a(8'h04, 10);
        ifa.tick = 1'b1; ifa.led = 8'h10;
        cyc(1);
        ifa.tick = 1'b0;
        lit("oo_pulse_pre", int'(ifa.err_pulse), m_pulse[0], 0);
        cyc(1);
        lit("oo_pulse",  int'(ifa.err_pulse), m_pulse[0],  1);
        lit("oo_errcnt", int'(ifa.err_count), m_cnt[0],    1);
        lit("oo_locked", int'(ifa.locked),    m_locked[0], 0);
        cyc(1);
        lit("oo_pulse_post", int'(ifa.err_pulse), m_pulse[0], 0);
        cyc(7);
        step_a(8'h20, 10);
        step_a(8'h40, 10);
        step_a(8'h80, 10);
        lit("relock", int'(ifa.locked), m_locked[0], 1);

        // Two bits set while locked is an error; zero bits in SEARCH is not.
        step_a(8'h18, 10);
        lit("multi_errcnt", int'(ifa.err_count), m_cnt[0],    2);
        lit("multi_locked", int'(ifa.locked),    m_locked[0], 0);
        step_a(8'h01, 10);
        step_a(8'h00, 10);
        step_a(8'h02, 10);
        step_a(8'h04, 10);
        lit("zero_nolock", int'(ifa.locked),    m_locked[0], 0);
        lit("zero_errcnt", int'(ifa.err_count), m_cnt[0],    2);
        step_a(8'h08, 10);
        lit("zero_relock", int'(ifa.locked), m_locked[0], 1);

        // Stop ticking while locked.
        cyc(25);
        lit("to_stall",  int'(ifa.stall),     m_stall[0],  1);
        lit("to_errcnt", int'(ifa.err_count), m_cnt[0],    3);
        lit("to_locked", int'(ifa.locked),    m_locked[0], 0);
        ifa.clr_err = 1'b1;
        cyc(1);
        ifa.clr_err = 1'b0;
        lit("clr_stall",  int'(ifa.stall),     m_stall[0], 0);
        lit("clr_errcnt", int'(ifa.err_count), m_cnt[0],   0);

        // Down-counting instance: 0 -> 7 wrap.
        step_b(8'h04, 10);
        step_b(8'h02, 10);
        step_b(8'h01, 10);
        step_b(8'h80, 10);
        step_b(8'h40, 10);
        lit("dn_locked", int'(ifb.locked),    m_locked[1], 1);
        lit("dn_errcnt", int'(ifb.err_count), m_cnt[1],    0);
        lit("dn_cur6",   int'(ifb.cur_idx),   m_cur[1],    6);

        // 260 lock/error rounds: counter must stick at 255.
        for (int i = 0; i < 260; i++) begin
            step_a(8'h01, 2);
            step_a(8'h02, 2);
            step_a(8'h04, 2);
            step_a(8'h00, 2);
        end
        cyc(2);
        lit("sat_errcnt", int'(ifa.err_count), m_cnt[0], 255);

        // Clear coincident with an error: clear wins, pulse still fires.
        step_a(8'h01, 2);
        step_a(8'h02, 2);
        step_a(8'h04, 2);
        ifa.tick = 1'b1; ifa.led = 8'h00;
        cyc(1);
        ifa.tick = 1'b0;
        ifa.clr_err = 1'b1;
        cyc(1);
        ifa.clr_err = 1'b0;
        lit("clrwin_pulse",  int'(ifa.err_pulse), m_pulse[0], 1);
        lit("clrwin_errcnt", int'(ifa.err_count), m_cnt[0],   0);

        // Asynchronous reset mid-lock, then reacquire.
        cyc(2);
        step_a(8'h01, 2);
        step_a(8'h02, 2);
        step_a(8'h04, 2);
        lit("pre_rst_locked", int'(ifa.locked), m_locked[0], 1);
        #2;
        rst = 1'b0;
        #1;
        lit("arst_locked", int'(ifa.locked),    m_locked[0], 0);
        lit("arst_cur",    int'(ifa.cur_idx),   m_cur[0],    0);
        lit("arst_errcnt", int'(ifa.err_count), m_cnt[0],    0);
        lit("arst_stall",  int'(ifa.stall),     m_stall[0],  0);
        lit("arst_pulse",  int'(ifa.err_pulse), m_pulse[0],  0);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        lit("post_rst_locked", int'(ifa.locked), m_locked[0], 0);
        step_a(8'h08, 2);
        step_a(8'h10, 2);
        step_a(8'h20, 2);
        lit("reacq_locked", int'(ifa.locked),  m_locked[0], 1);
        lit("reacq_cur5",   int'(ifa.cur_idx), m_cur[0],    5);
        cyc(3);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
